// File: rtl/fan_pwm_gen.sv
// rtl/fan_pwm_gen.sv - fixed-period fan PWM generator with per-period duty ramp
//
// Purpose: turns an enable plus a 2-bit speed level into a PWM drive whose
// duty only changes at period boundaries. With FAN_PWM_SOFTSTART_EN defined,
// the duty walks toward its target by STEP per period (soft start/stop).
// Without it, the duty jumps straight to the target at each boundary.
//
// Ports:
//   clk_in       PWM tick clock
//   rst_n        asynchronous active-low reset
//   en           fan enable; low forces a zero target
//   speed_level  0 off, 1/2/3 select L1/L2/L3_DUTY
//   pwm_out      registered PWM drive, high for cur_duty cycles per period
//   period_start one-cycle pulse in the first cycle of each period
//   cur_duty     duty currently applied
//   fan_state    0 OFF, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
//
// Configuration macro: FAN_PWM_SOFTSTART_EN

module fan_pwm_gen #(
  parameter int unsigned PERIOD  = 20,
  parameter int unsigned STEP    = 5,
  parameter int unsigned L1_DUTY = 5,
  parameter int unsigned L2_DUTY = 10,
  parameter int unsigned L3_DUTY = 20,
  parameter int unsigned DUTY_W  = 5
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        speed_level,
  output logic              pwm_out,
  output logic              period_start,
  output logic [DUTY_W-1:0] cur_duty,
  output logic [1:0]        fan_state
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  localparam int unsigned       W1       = DUTY_W + 1;
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);

`ifdef FAN_PWM_SOFTSTART_EN
  localparam logic [W1-1:0] STEP_V = W1'(STEP);
`else
  // An all-ones step is never smaller than the gap to target, so every
  // boundary lands directly on the target and the ramp states never occur.
  localparam logic [W1-1:0] STEP_V = W1'(STEP) | {W1{1'b1}};
`endif

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target;
  logic [W1-1:0]     duty_ext, target_ext, gap;
  logic              pwm_q, pwm_d;
  logic              ps_q, ps_d;
  logic              boundary;
  state_e            state_q, state_d;

  always_comb begin
    target = '0;
    if (en) begin
      case (speed_level)
        2'd1:    target = DUTY_W'(L1_DUTY);
        2'd2:    target = DUTY_W'(L2_DUTY);
        2'd3:    target = DUTY_W'(L3_DUTY);
        default: target = '0;
      endcase
    end
  end

  always_comb begin
    boundary = (cnt_q == CNT_LAST);
    cnt_d    = boundary ? '0 : cnt_q + DUTY_W'(1);
  end

  // Stepping works on the gap to target, so the result saturates at target
  // from either side and can neither overflow nor underflow.
  always_comb begin
    duty_ext   = {1'b0, duty_q};
    target_ext = {1'b0, target};
    gap        = '0;
    duty_d     = duty_q;
    if (boundary) begin
      if (target_ext > duty_ext) begin
        gap    = target_ext - duty_ext;
        duty_d = (gap > STEP_V) ? DUTY_W'(duty_ext + STEP_V) : target;
      end else if (target_ext < duty_ext) begin
        gap    = duty_ext - target_ext;
        duty_d = (gap > STEP_V) ? DUTY_W'(duty_ext - STEP_V) : target;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (boundary) begin
      if (duty_d == target) begin
        state_d = (target == '0) ? ST_OFF : ST_RUN;
      end else if (duty_d < target) begin
        state_d = ST_RAMP_UP;
      end else begin
        state_d = ST_RAMP_DOWN;
      end
    end
  end

  // Loading pwm from next-state values keeps the output aligned with the
  // counter and lets a new duty take effect on the same boundary edge.
  always_comb begin
    pwm_d = (cnt_d < duty_d);
    ps_d  = boundary;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      state_q <= ST_OFF;
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      state_q <= state_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
    end
  end

  // The reset term keeps every output low during reset even though the
  // flops already clear asynchronously.
  assign pwm_out      = pwm_q & rst_n;
  assign period_start = ps_q & rst_n;
  assign cur_duty     = duty_q;
  assign fan_state    = state_q;

endmodule

// File: tb/tb_fan_pwm_gen.sv
// tb/tb_fan_pwm_gen.sv - directed self-checking bench for fan_pwm_gen

module tb_fan_pwm_gen;

  logic       clk_in;
  logic       rst_n;
  logic       en;
  logic [1:0] speed_level;
  logic       pwm_out;
  logic       period_start;
  logic [4:0] cur_duty;
  logic [1:0] fan_state;

  int checks = 0;
  int errors = 0;

`ifdef FAN_PWM_SOFTSTART_EN
  localparam int UP_N = 4;
  localparam int L2_N = 2;
  localparam int L3_N = 2;
  localparam int DN_N = 4;
  int up_duty [UP_N] = '{5, 10, 15, 20};
  int up_state[UP_N] = '{1, 1, 1, 2};
  int l2_duty [L2_N] = '{15, 10};
  int l2_state[L2_N] = '{3, 2};
  int l3_duty [L3_N] = '{15, 20};
  int l3_state[L3_N] = '{1, 2};
  int dn_duty [DN_N] = '{15, 10, 5, 0};
  int dn_state[DN_N] = '{3, 3, 3, 0};
  localparam int RST_PRE = 10;
`else
  localparam int UP_N = 1;
  localparam int L2_N = 1;
  localparam int L3_N = 1;
  localparam int DN_N = 1;
  int up_duty [UP_N] = '{20};
  int up_state[UP_N] = '{2};
  int l2_duty [L2_N] = '{10};
  int l2_state[L2_N] = '{2};
  int l3_duty [L3_N] = '{20};
  int l3_state[L3_N] = '{2};
  int dn_duty [DN_N] = '{0};
  int dn_state[DN_N] = '{0};
  localparam int RST_PRE = 20;
`endif

  fan_pwm_gen dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .speed_level (speed_level),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .cur_duty    (cur_duty),
    .fan_state   (fan_state)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bnd(input string tag, input int duty, input int st);
    check({tag, "_duty"}, 32'(cur_duty), duty);
    check({tag, "_state"}, 32'(fan_state), st);
  endtask

  // Starts on the negedge right after a boundary edge and walks one period,
  // ending on the negedge after the next boundary edge.
  task automatic check_period(input string tag, input int duty);
    for (int k = 0; k < 20; k++) begin
      check({tag, "_pwm"}, 32'(pwm_out), (k < duty) ? 1 : 0);
      check({tag, "_ps"}, 32'(period_start), (k == 0) ? 1 : 0);
      tick(1);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b1;
    speed_level = 2'd3;
    tick(3);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_ps", 32'(period_start), 0);
    check_bnd("rst", 0, 0);

    rst_n = 1'b1;
    tick(19);
    check("pre_bnd_ps", 32'(period_start), 0);
    check("pre_bnd_pwm", 32'(pwm_out), 0);
    check_bnd("pre_bnd", 0, 0);
    tick(1);

    for (int i = 0; i < UP_N; i++) begin
      check_bnd("up", up_duty[i], up_state[i]);
      check_period("up", up_duty[i]);
    end
    check_bnd("run3", 20, 2);

    tick(5);
    speed_level = 2'd1;
    tick(5);
    speed_level = 2'd3;
    tick(10);
    check_bnd("toggle", 20, 2);

    speed_level = 2'd2;
    check_period("to_l2", 20);
    for (int i = 0; i < L2_N; i++) begin
      check_bnd("l2", l2_duty[i], l2_state[i]);
      check_period("l2", l2_duty[i]);
    end
    check_bnd("l2_steady", 10, 2);
    check_period("l2_steady", 10);

    speed_level = 2'd3;
    check_period("to_l3", 10);
    for (int i = 0; i < L3_N; i++) begin
      check_bnd("l3", l3_duty[i], l3_state[i]);
      check_period("l3", l3_duty[i]);
    end

    en = 1'b0;
    check_bnd("en_drop", 20, 2);
    check_period("en_drop", 20);
    for (int i = 0; i < DN_N; i++) begin
      check_bnd("dn", dn_duty[i], dn_state[i]);
      check_period("dn", dn_duty[i]);
    end

    en = 1'b1;
    check_period("restart", 0);
`ifdef FAN_PWM_SOFTSTART_EN
    check_bnd("restart1", 5, 1);
    check_period("restart1", 5);
    check_bnd("restart2", 10, 1);
`else
    check_bnd("restart1", 20, 2);
`endif
    tick(7);
    check("pre_rst_pwm", 32'(pwm_out), 1);
    check("pre_rst_duty", 32'(cur_duty), RST_PRE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pwm", 32'(pwm_out), 0);
    check("async_ps", 32'(period_start), 0);
    check_bnd("async", 0, 0);

    @(negedge clk_in);
    rst_n = 1'b1;
    tick(19);
    check("post_rst_ps0", 32'(period_start), 0);
    check("post_rst_duty0", 32'(cur_duty), 0);
    tick(1);
    check("post_rst_ps1", 32'(period_start), 1);
    check_bnd("post_rst", up_duty[0], up_state[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
